// File: rtl/mpu_tile_io.sv
// mpu_tile_io: moves whole accumulator tiles between the opacc shift array
// and a streaming row port using four commands: LOAD, STORE_KEEP, STORE_CLEAR, ZERO.
// Ports:
//   cmd_*                  command handshake (op, target tile)
//   in_*                   load row stream
//   out_*                  store row stream
//   ci_valid/ci_addr/ci    shift strobe, target tile and row shifted into opacc row 0
//   co_addr/co             tile select and that tile's row ML-1
//   busy_mask              one-hot of the tile being moved
//   done                   one-cycle pulse when a command completes
module mpu_tile_io #(
  parameter int NREGS = 2,
  parameter int VL    = 4,
  parameter int ML    = 4,
  parameter int XLEN  = 64,
  localparam int RW   = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int CW   = $clog2(ML + 1),
  localparam int DW   = VL * XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RW-1:0]    cmd_reg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             ci_valid,
  output logic [RW-1:0]    ci_addr,
  output logic [DW-1:0]    ci,
  output logic [RW-1:0]    co_addr,
  input  logic [DW-1:0]    co,
  output logic [NREGS-1:0] busy_mask,
  output logic             done
);

  localparam logic [1:0] OP_LD = 2'b00;
  localparam logic [1:0] OP_SK = 2'b01;
  localparam logic [1:0] OP_SC = 2'b10;
  localparam logic [1:0] OP_ZR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_ZERO
  } state_e;

  state_e        state_q;
  logic [1:0]    op_q;
  logic [RW-1:0] reg_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          done_q;
  logic          xfer;
  logic          last;

  // One row moves per cycle in which the active stream side is willing.
  assign xfer = ((state_q == S_LOAD) && in_valid)
              | ((state_q == S_STORE) && out_ready)
              | (state_q == S_ZERO);

  assign cnt_d = cnt_q + CW'(1);
  assign last  = xfer && (cnt_q == CW'(ML - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      reg_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            reg_q <= cmd_reg;
            cnt_q <= '0;
            case (cmd_op)
              OP_LD:   state_q <= S_LOAD;
              OP_ZR:   state_q <= S_ZERO;
              default: state_q <= S_STORE;
            endcase
          end
        end
        default: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (last) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_STORE);
  assign ci_valid  = xfer;
  assign out_data  = co;
  assign ci_addr   = reg_q;
  assign co_addr   = reg_q;
  assign done      = done_q;

  assign busy_mask = (state_q == S_IDLE) ? '0 : (NREGS'(1) << reg_q);

  // STORE_KEEP feeds row ML-1 back into row 0, so ML beats rotate the
  // tile back to its original contents; STORE_CLEAR and ZERO shift in zeros.
  always_comb begin
    ci = '0;
    if (state_q == S_LOAD) begin
      ci = in_data;
    end else if ((state_q == S_STORE) && (op_q == OP_SK)) begin
      ci = co;
    end
  end

  // OP_SC is decoded through the default STORE branch.
  logic unused_op;
  assign unused_op = (OP_SC == 2'b10);

endmodule

// File: tb/tb_mpu_tile_io.sv
// tb_mpu_tile_io: drives mpu_tile_io against a shift-array opacc and checks
// every cycle against a tile-level model, plus directed literal scenarios.
module tb_mpu_tile_io;

  localparam int NREGS = 2;
  localparam int VL    = 4;
  localparam int ML    = 4;
  localparam int XLEN  = 64;
  localparam int RW    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int DW    = VL * XLEN;

  localparam logic [1:0] OP_LD = 2'b00;
  localparam logic [1:0] OP_SK = 2'b01;
  localparam logic [1:0] OP_SC = 2'b10;
  localparam logic [1:0] OP_ZR = 2'b11;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [RW-1:0]    cmd_reg;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             ci_valid;
  logic [RW-1:0]    ci_addr;
  logic [DW-1:0]    ci;
  logic [RW-1:0]    co_addr;
  logic [DW-1:0]    co;
  logic [NREGS-1:0] busy_mask;
  logic             done;

  mpu_tile_io #(
    .NREGS(NREGS), .VL(VL), .ML(ML), .XLEN(XLEN)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ci_valid(ci_valid), .ci_addr(ci_addr), .ci(ci),
    .co_addr(co_addr), .co(co),
    .busy_mask(busy_mask), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [XLEN-1:0] v);
    return {VL{v}};
  endfunction

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*XLEN +: XLEN] = {$urandom, $urandom};
    return v;
  endfunction

  // opacc environment: a per-tile shift array
  logic [DW-1:0] opacc [NREGS][ML];
  bit            env_init = 0;
  logic          s_civ;
  logic [RW-1:0] s_ciaddr;
  logic [DW-1:0] s_ci;

  assign co = opacc[co_addr][ML-1];

  always @(posedge clk) begin
    if (!env_init) begin
      for (int t = 0; t < NREGS; t++)
        for (int k = 0; k < ML; k++) opacc[t][k] <= '0;
      env_init <= 1'b1;
    end else if (s_civ === 1'b1) begin
      for (int k = ML - 1; k > 0; k--)
        opacc[s_ciaddr][k] <= opacc[s_ciaddr][k-1];
      opacc[s_ciaddr][0] <= s_ci;
    end
  end

  // stimulus side-channels
  logic [DW-1:0] data_q [$];
  bit            iv_pat [$];
  bit            or_pat [$];
  bit            rnd_mode = 0;
  bit            load_hs  = 0;
  int            civ_cnt  = 0;
  int            dcount   = 0;
  logic [DW-1:0] got [$];

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (load_hs && data_q.size() > 0) void'(data_q.pop_front());
      in_data = (data_q.size() > 0) ? data_q[0] : rnd_row();
      if (iv_pat.size() > 0) in_valid = iv_pat.pop_front();
      else in_valid = rnd_mode ? 1'($urandom % 2) : 1'b1;
      if (or_pat.size() > 0) out_ready = or_pat.pop_front();
      else out_ready = rnd_mode ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Tile-level model: L[t][k] is the k-th row in load order.
  logic [DW-1:0] L [NREGS][ML];
  logic [DW-1:0] stage [ML];
  bit            known [NREGS];
  bit            m_act  = 0;
  logic [1:0]    m_op   = '0;
  int            m_reg  = 0;
  int            m_beats = 0;
  bit            m_done = 0;
  bit            synced = 0;

  initial begin
    bit               xf;
    logic [NREGS-1:0] eb;
    for (int t = 0; t < NREGS; t++) begin
      known[t] = 1'b1;
      for (int k = 0; k < ML; k++) L[t][k] = '0;
    end
    forever begin
      @(negedge clk);
      s_civ    = ci_valid;
      s_ciaddr = ci_addr;
      s_ci     = ci;
      load_hs  = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (ci_valid === 1'b1) civ_cnt++;
      if (done === 1'b1) dcount++;
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);

      xf = m_act && ((m_op == OP_LD) ? in_valid :
                     (m_op == OP_ZR) ? 1'b1 : out_ready);
      eb = m_act ? (NREGS'(1) << m_reg) : '0;

      if (synced) begin
        chk("cmd_ready", DW'(cmd_ready), DW'(!m_act));
        chk("busy_mask", DW'(busy_mask), DW'(eb));
        chk("in_ready", DW'(in_ready), DW'(m_act && m_op == OP_LD));
        chk("out_valid", DW'(out_valid),
            DW'(m_act && (m_op == OP_SK || m_op == OP_SC)));
        chk("ci_valid", DW'(ci_valid), DW'(xf));
        chk("done", DW'(done), DW'(m_done));
        chk("ci_addr", DW'(ci_addr), DW'(m_reg));
        chk("co_addr", DW'(co_addr), DW'(m_reg));
        if (m_act && (m_op == OP_SK || m_op == OP_SC) && known[m_reg])
          chk("out_data", out_data, L[m_reg][m_beats]);
        if (xf) begin
          case (m_op)
            OP_LD: chk("ci_load", ci, in_data);
            OP_SK: if (known[m_reg]) chk("ci_keep", ci, L[m_reg][m_beats]);
            default: chk("ci_zero", ci, '0);
          endcase
        end
      end

      if (reset === 1'b1) begin
        if (m_act) known[m_reg] = 1'b0;
        m_act  = 0;
        m_op   = '0;
        m_reg  = 0;
        m_done = 0;
        synced = 1;
      end else begin
        m_done = 0;
        if (!m_act) begin
          if (cmd_valid) begin
            m_act   = 1;
            m_op    = cmd_op;
            m_reg   = int'(cmd_reg);
            m_beats = 0;
          end
        end else if (xf) begin
          if (m_op == OP_LD) stage[m_beats] = in_data;
          m_beats++;
          if (m_beats == ML) begin
            for (int k = 0; k < ML; k++) begin
              if (m_op == OP_LD) L[m_reg][k] = stage[k];
              else if (m_op != OP_SK) L[m_reg][k] = '0;
            end
            if (m_op != OP_SK) known[m_reg] = 1'b1;
            m_act  = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance.
  task automatic issue(input logic [1:0] op, input int r);
    int n;
    n = 0;
    cmd_op    = op;
    cmd_reg   = RW'(r);
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL issue: got timeout want cmd_ready");
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int ncyc);
    ncyc = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (done === 1'b1) break;
      if (ncyc >= 400) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_done: got timeout want done");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rows(input string nm, input logic [XLEN-1:0] base,
                          input bit zero);
    logic [DW-1:0] e;
    chk({nm, "_count"}, DW'(got.size()), DW'(ML));
    for (int k = 0; k < ML; k++) begin
      e = zero ? '0 : rep(base + XLEN'(k));
      chk($sformatf("%s_row%0d", nm, k),
          (got.size() > k) ? got[k] : {DW{1'bx}}, e);
    end
  endtask

  initial begin
    int nc;
    int d0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_reg   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", DW'(cmd_ready), DW'(1));
    chk("rst_busy", DW'(busy_mask), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_civ", DW'(ci_valid), '0);
    @(posedge clk);
    #1;

    // load then two non-destructive stores
    for (int k = 0; k < ML; k++) data_q.push_back(rep(64'h10 + 64'(k)));
    issue(OP_LD, 1);
    wait_done(nc);
    got.delete();
    issue(OP_SK, 1);
    wait_done(nc);
    chk_rows("keep1", 64'h10, 0);
    got.delete();
    issue(OP_SK, 1);
    wait_done(nc);
    chk_rows("keep2", 64'h10, 0);

    // clearing store, then the tile reads back as zeros
    got.delete();
    d0 = dcount;
    issue(OP_SC, 1);
    wait_done(nc);
    chk("clr_cycles", DW'(nc), DW'(ML + 1));
    chk_rows("clr", 64'h10, 0);
    chk("clr_done_cnt", DW'(dcount - d0), DW'(1));
    got.delete();
    issue(OP_SK, 1);
    wait_done(nc);
    chk_rows("after_clr", 64'h0, 1);

    // load with gaps in in_valid
    for (int k = 0; k < ML; k++) data_q.push_back(rep(64'h20 + 64'(k)));
    issue(OP_LD, 0);
    iv_pat = '{1, 0, 0, 1, 1, 0, 1};
    civ_cnt = 0;
    wait_done(nc);
    chk("gap_civ", DW'(civ_cnt), DW'(4));
    chk("gap_cycles", DW'(nc), DW'(8));

    // store with a 5-cycle out_ready stall
    got.delete();
    issue(OP_SK, 0);
    or_pat = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
    civ_cnt = 0;
    wait_done(nc);
    chk("stall_civ", DW'(civ_cnt), DW'(4));
    chk("stall_cycles", DW'(nc), DW'(10));
    chk_rows("stall", 64'h20, 0);

    // command held during a load is taken only in the done cycle
    issue(OP_LD, 0);
    cmd_op    = OP_SK;
    cmd_reg   = RW'(1);
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("hold_busy0", DW'(busy_mask), DW'(2'b01));
    nc = 0;
    while (cmd_ready !== 1'b1 && nc < 50) begin
      @(negedge clk);
      nc++;
    end
    chk("hold_acc_done", DW'(done), DW'(1));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_busy1", DW'(busy_mask), DW'(2'b10));
    @(posedge clk);
    #1;
    wait_done(nc);

    // reset after two load beats aborts silently
    issue(OP_LD, 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    d0 = dcount;
    @(negedge clk);
    chk("abort_ready", DW'(cmd_ready), DW'(1));
    chk("abort_busy", DW'(busy_mask), '0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", DW'(dcount - d0), '0);
    @(posedge clk);
    #1;
    issue(OP_ZR, 1);
    wait_done(nc);

    // randomized commands and handshakes
    rnd_mode = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
      issue(2'($urandom % 4), int'($urandom % NREGS));
      wait_done(nc);
    end
    rnd_mode = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
